// File: rtl/tl_rr_arbiter.sv
// Round-robin arbiter for TileLink A-channel masters onto one downstream port.
// Grants are locked from first offer until the last beat of the message is accepted.
module tl_rr_arbiter #(
    parameter int unsigned n = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [n-1:0] in_valid,
    input  logic [n-1:0] in_last,
    output logic [n-1:0] in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [n-1:0] select,
    output logic         busy
);

    localparam int unsigned PtrW = (n > 1) ? $clog2(n) : 1;
    localparam int unsigned CandW = PtrW + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StHold  = 2'd1;
    localparam logic [1:0] StBurst = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] owner_q, owner_d;

    logic [PtrW-1:0]  grant_idx;
    logic             grant_found;
    logic [CandW-1:0] cand;
    logic [PtrW-1:0]  cur_idx;
    logic [PtrW-1:0]  ptr_inc;
    logic             sel_any;
    logic             fire;

    // Scan in_valid starting at ptr, wrapping modulo n.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < n; k++) begin
            cand = {1'b0, ptr_q} + CandW'(k);
            if (cand >= CandW'(n)) begin
                cand = cand - CandW'(n);
            end
            if (!grant_found && in_valid[cand[PtrW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PtrW-1:0];
            end
        end
    end

    always_comb begin
        cur_idx   = (state_q == StIdle) ? grant_idx : owner_q;
        sel_any   = (state_q != StIdle) || grant_found;
        select    = sel_any ? (n'(1) << cur_idx) : '0;
        out_valid = |(in_valid & select);
        out_last  = |(in_last & select);
        in_ready  = select & {n{out_ready}};
        fire      = out_valid & out_ready;
        busy      = (state_q != StIdle);
        ptr_inc   = (cur_idx == PtrW'(n - 1)) ? '0 : cur_idx + PtrW'(1);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            StIdle: begin
                if (grant_found) begin
                    if (fire && out_last) begin
                        ptr_d = ptr_inc;
                    end else begin
                        // Unaccepted offers lock too, so the offer cannot switch masters.
                        owner_d = grant_idx;
                        state_d = fire ? StBurst : StHold;
                    end
                end
            end
            StHold: begin
                if (fire && out_last) begin
                    state_d = StIdle;
                    ptr_d   = ptr_inc;
                end else if (fire) begin
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (fire && out_last) begin
                    state_d = StIdle;
                    ptr_d   = ptr_inc;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_tl_rr_arbiter.sv
// Directed bench for tl_rr_arbiter: fairness, burst lock, backpressure, wrap, reset.
module tb_tl_rr_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] in_valid;
    logic [3:0] in_last;
    logic [3:0] in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [3:0] select;
    logic       busy;

    int checks;
    int failures;

    tl_rr_arbiter #(.n(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .select   (select),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    logic [3:0] fair_sel [8];

    initial begin
        checks    = 0;
        failures  = 0;
        fair_sel  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                      4'b0001, 4'b0010, 4'b0100, 4'b1000};
        reset     = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_select", 32'(select), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        tick();

        // Fairness: all masters single-beat, always ready.
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("fair_select", 32'(select), 32'(fair_sel[i]));
            chk("fair_in_ready", 32'(in_ready), 32'(fair_sel[i]));
            chk("fair_out_last", 32'(out_last), 32'h1);
            chk("fair_busy", 32'(busy), 32'h0);
            tick();
        end

        // Move ptr to 1 with a single beat from master 0.
        in_valid = 4'b0001;
        in_last  = 4'b0001;
        #1;
        chk("pre_burst_select", 32'(select), 32'h1);
        tick();

        // Burst lock: master 1 four beats, bubble after beat 2, master 0 valid throughout.
        in_valid = 4'b0011;
        in_last  = 4'b0000;
        #1;
        chk("burst_b1_select", 32'(select), 32'h2);
        chk("burst_b1_busy", 32'(busy), 32'h0);
        tick();
        #1;
        chk("burst_b2_select", 32'(select), 32'h2);
        chk("burst_b2_busy", 32'(busy), 32'h1);
        tick();
        in_valid = 4'b0001;
        #1;
        chk("burst_bubble_select", 32'(select), 32'h2);
        chk("burst_bubble_out_valid", 32'(out_valid), 32'h0);
        chk("burst_bubble_busy", 32'(busy), 32'h1);
        tick();
        in_valid = 4'b0011;
        #1;
        chk("burst_b3_select", 32'(select), 32'h2);
        chk("burst_b3_busy", 32'(busy), 32'h1);
        tick();
        in_last = 4'b0010;
        #1;
        chk("burst_b4_select", 32'(select), 32'h2);
        chk("burst_b4_out_last", 32'(out_last), 32'h1);
        chk("burst_b4_busy", 32'(busy), 32'h1);
        tick();
        in_valid = 4'b0001;
        in_last  = 4'b0001;
        #1;
        chk("burst_after_select", 32'(select), 32'h1);
        chk("burst_after_busy", 32'(busy), 32'h0);
        tick();

        // Backpressure hold on master 2 (ptr is 1 here).
        in_valid  = 4'b0100;
        in_last   = 4'b0100;
        out_ready = 1'b0;
        #1;
        chk("hold_c1_select", 32'(select), 32'h4);
        chk("hold_c1_in_ready", 32'(in_ready), 32'h0);
        tick();
        in_valid = 4'b0101;
        in_last  = 4'b0101;
        #1;
        chk("hold_c2_select", 32'(select), 32'h4);
        chk("hold_c2_in_ready", 32'(in_ready), 32'h0);
        chk("hold_c2_busy", 32'(busy), 32'h1);
        tick();
        #1;
        chk("hold_c3_select", 32'(select), 32'h4);
        chk("hold_c3_in_ready", 32'(in_ready), 32'h0);
        tick();
        out_ready = 1'b1;
        #1;
        chk("hold_fire_select", 32'(select), 32'h4);
        chk("hold_fire_in_ready", 32'(in_ready), 32'h4);
        chk("hold_fire_out_valid", 32'(out_valid), 32'h1);
        tick();

        // Wrap and skip: ptr is 3, masters 3 and 1 valid.
        in_valid = 4'b1010;
        in_last  = 4'b1010;
        #1;
        chk("wrap_select", 32'(select), 32'h8);
        chk("wrap_busy", 32'(busy), 32'h0);
        tick();
        #1;
        chk("skip_select", 32'(select), 32'h2);
        tick();

        // Reset mid-burst of master 3 (ptr is 2 here).
        in_valid = 4'b1000;
        in_last  = 4'b0000;
        #1;
        chk("rstb_b1_select", 32'(select), 32'h8);
        tick();
        in_valid = 4'b1001;
        reset    = 1'b1;
        #1;
        chk("rstb_b2_select", 32'(select), 32'h8);
        chk("rstb_b2_busy", 32'(busy), 32'h1);
        tick();
        reset = 1'b0;
        #1;
        chk("rstb_after_busy", 32'(busy), 32'h0);
        chk("rstb_after_select", 32'(select), 32'h1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
